// File: rtl/switch_channel_mux_pkg.sv
// Shared types and helpers for the switch-driven channel mux.
package switch_channel_mux_pkg;

    localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_NEXT = 2'd1,
        STEP_PREV = 2'd2
    } step_e;

    // Simultaneous Next and Prev rises cancel, so the pointer holds.
    function automatic step_e step_decode(input logic next_rise, input logic prev_rise);
        step_e s;
        s = STEP_NONE;
        if (next_rise && !prev_rise) s = STEP_NEXT;
        else if (prev_rise && !next_rise) s = STEP_PREV;
        return s;
    endfunction

endpackage

// File: rtl/switch_channel_mux_debounce.sv
// Single-switch debouncer: the output follows the raw input only after the raw
// level has differed from it for DEBOUNCE_LIMIT consecutive cycles.
module switch_debounce
    import switch_channel_mux_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch
);

    localparam int CNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             state_q;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else if (i_Switch == state_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_LIMIT - 1)) begin
            cnt_q   <= '0;
            state_q <= i_Switch;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_Switch = state_q;

endmodule

// File: rtl/switch_channel_mux.sv
// Push-switch driven channel selector: debounced Next/Prev step a wrapping
// pointer, the selected channel is registered onto o_Data unless Hold is set.
module switch_channel_mux
    import switch_channel_mux_pkg::*;
#(
    parameter  int CHANNELS       = 4,
    parameter  int WIDTH          = 4,
    parameter  int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    localparam int SEL_W          = $clog2(CHANNELS)
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_L,
    input  logic                      i_Switch_Next,
    input  logic                      i_Switch_Prev,
    input  logic                      i_Switch_Hold,
    input  logic [CHANNELS*WIDTH-1:0] i_Data,
    output logic [WIDTH-1:0]          o_Data,
    output logic [SEL_W-1:0]          o_Sel,
    output logic [CHANNELS-1:0]       o_Sel_Onehot,
    output logic                      o_Sel_Changed
);

    logic next_db, prev_db, hold_db;

    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_next (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch_Next), .o_Switch(next_db)
    );
    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_prev (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch_Prev), .o_Switch(prev_db)
    );
    switch_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_hold (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch_Hold), .o_Switch(hold_db)
    );

    logic                next_db_q, prev_db_q;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CHANNELS-1:0] onehot_q, onehot_d;
    logic [WIDTH-1:0]    data_q, sel_data;
    logic                changed_q;
    step_e               step;

    assign step = step_decode(next_db & ~next_db_q, prev_db & ~prev_db_q);

    // Explicit wrap compares keep the pointer inside 0..CHANNELS-1 for any count.
    always_comb begin
        sel_d = sel_q;
        case (step)
            STEP_NEXT: sel_d = (sel_q == SEL_W'(CHANNELS - 1)) ? '0 : sel_q + SEL_W'(1);
            STEP_PREV: sel_d = (sel_q == '0) ? SEL_W'(CHANNELS - 1) : sel_q - SEL_W'(1);
            default:   sel_d = sel_q;
        endcase
    end

    always_comb begin
        onehot_d = '0;
        for (int k = 0; k < CHANNELS; k++)
            onehot_d[k] = (sel_d == SEL_W'(k));
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++)
            if (sel_q == SEL_W'(k)) sel_data = i_Data[k*WIDTH +: WIDTH];
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            next_db_q <= 1'b0;
            prev_db_q <= 1'b0;
            sel_q     <= '0;
            onehot_q  <= CHANNELS'(1);
            data_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            next_db_q <= next_db;
            prev_db_q <= prev_db;
            sel_q     <= sel_d;
            onehot_q  <= onehot_d;
            changed_q <= (step != STEP_NONE);
            if (!hold_db) data_q <= sel_data;
        end
    end

    assign o_Data        = data_q;
    assign o_Sel         = sel_q;
    assign o_Sel_Onehot  = onehot_q;
    assign o_Sel_Changed = changed_q;

endmodule

// File: tb/tb_switch_channel_mux.sv
// Directed bench for switch_channel_mux with a short debounce window.
module tb_switch_channel_mux;

    localparam int CH = 3;
    localparam int W  = 4;
    localparam int DL = 4;
    localparam int SW = $clog2(CH);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sw_next, sw_prev, sw_hold;
    logic [CH*W-1:0] data_in;
    logic [W-1:0]    data_out;
    logic [SW-1:0]   sel;
    logic [CH-1:0]   onehot;
    logic            changed;

    int n_cmp  = 0;
    int n_bad  = 0;
    int pulses = 0;
    int p0;

    switch_channel_mux #(.CHANNELS(CH), .WIDTH(W), .DEBOUNCE_LIMIT(DL)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n),
        .i_Switch_Next(sw_next), .i_Switch_Prev(sw_prev), .i_Switch_Hold(sw_hold),
        .i_Data(data_in), .o_Data(data_out), .o_Sel(sel),
        .o_Sel_Onehot(onehot), .o_Sel_Changed(changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (changed) pulses <= pulses + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean Next press: pointer steps 5 cycles after the press, data one cycle later.
    task automatic press_next(input int exp_sel, input logic [3:0] old_d, input logic [3:0] new_d);
        sw_next = 1'b1;
        tick(5);
        chk("next_sel", 32'(sel), 32'(exp_sel));
        chk("next_pulse", 32'(changed), 32'd1);
        chk("next_data_old", 32'(data_out), 32'(old_d));
        tick(1);
        chk("next_data_new", 32'(data_out), 32'(new_d));
        chk("next_pulse_end", 32'(changed), 32'd0);
        sw_next = 1'b0;
        tick(6);
        chk("next_release_sel", 32'(sel), 32'(exp_sel));
    endtask

    initial begin
        rst_n = 1'b0; sw_next = 1'b0; sw_prev = 1'b0; sw_hold = 1'b0;
        data_in = {4'hC, 4'hB, 4'hA};

        // 1 reset
        tick(2);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_onehot", 32'(onehot), 32'b001);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_pulse", 32'(changed), 32'd0);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_data", 32'(data_out), 32'hA);

        // 2 bouncing Next never qualifies
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            sw_next = ~sw_next;
            tick(1);
        end
        sw_next = 1'b0;
        tick(6);
        chk("bounce_sel", 32'(sel), 32'd0);
        chk("bounce_pulses", 32'(pulses - p0), 32'd0);

        // 3 three Next presses with wrap
        p0 = pulses;
        press_next(1, 4'hA, 4'hB);
        data_in = {4'hC, 4'h5, 4'hA};
        tick(1);
        chk("live_data", 32'(data_out), 32'h5);
        data_in = {4'hC, 4'hB, 4'hA};
        tick(1);
        press_next(2, 4'hB, 4'hC);
        press_next(0, 4'hC, 4'hA);
        chk("next_pulses", 32'(pulses - p0), 32'd3);
        chk("wrap_onehot", 32'(onehot), 32'b001);

        // 4 Prev wraps down; simultaneous Next+Prev does nothing
        sw_prev = 1'b1;
        tick(5);
        chk("prev_sel", 32'(sel), 32'd2);
        chk("prev_onehot", 32'(onehot), 32'b100);
        chk("prev_pulse", 32'(changed), 32'd1);
        tick(1);
        chk("prev_data", 32'(data_out), 32'hC);
        sw_prev = 1'b0;
        tick(6);
        p0 = pulses;
        sw_next = 1'b1; sw_prev = 1'b1;
        tick(8);
        chk("both_sel", 32'(sel), 32'd2);
        chk("both_pulses", 32'(pulses - p0), 32'd0);
        sw_next = 1'b0; sw_prev = 1'b0;
        tick(6);

        // 5 Hold freezes data while pointer still steps
        sw_hold = 1'b1;
        tick(6);
        sw_next = 1'b1;
        tick(5);
        chk("hold_sel", 32'(sel), 32'd0);
        chk("hold_onehot", 32'(onehot), 32'b001);
        tick(1);
        chk("hold_data", 32'(data_out), 32'hC);
        sw_next = 1'b0;
        tick(6);
        sw_next = 1'b1;
        tick(6);
        chk("hold_sel2", 32'(sel), 32'd1);
        chk("hold_data2", 32'(data_out), 32'hC);
        sw_next = 1'b0;
        tick(6);
        sw_hold = 1'b0;
        tick(4);
        chk("unhold_still", 32'(data_out), 32'hC);
        tick(1);
        chk("unhold_data", 32'(data_out), 32'hB);

        // 6 reset mid-debounce discards the partial count
        sw_next = 1'b1;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_data", 32'(data_out), 32'h0);
        rst_n = 1'b1;
        tick(3);
        chk("midrst_nostep3", 32'(sel), 32'd0);
        tick(1);
        chk("midrst_nostep4", 32'(sel), 32'd0);
        tick(1);
        chk("midrst_step", 32'(sel), 32'd1);
        chk("midrst_pulse", 32'(changed), 32'd1);
        sw_next = 1'b0;
        tick(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
